// File: rtl/packet_scheduler_if.sv
// -----------------------------------------------------------------------------
// packet_scheduler_if
//
// Purpose: bundles the stimulus-side and formatter-side signals of the data
// island packet scheduler. Clock and reset stay plain ports on the module.
//
// Signals (direction as seen by the scheduler, i.e. the slave modport):
//   video_field_end           in   pulse at end of each video field
//   packet_enable             in   pulse: choose the next packet
//   packet_pixel_counter      in   position inside the current packet (0..31)
//   audio_sample_valid        in   sample push strobe
//   audio_sample_word         in   {right, left} sample pair
//   acr_request               in   ACR generator wrap pulse
//   packet_type               out  selected packet type
//   audio_sample_word_packet  out  4 slots x 2 channels x 24 bit payload
//   audio_sample_word_present out  per-slot valid bits
//   frame_counter             out  IEC 60958 frame index 0..191
//   fifo_level                out  FIFO occupancy
//   fifo_overflow             out  sticky sample-dropped flag
//   avmute / gcp_avmute       in / out, only with PACKET_SCHEDULER_GCP_EN
//
// Modports: master = upstream/environment side, slave = the scheduler.
// -----------------------------------------------------------------------------
interface packet_scheduler_if #(
    parameter int AUDIO_BIT_WIDTH = 24,
    parameter int FIFO_DEPTH      = 8
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic                         video_field_end;
    logic                         packet_enable;
    logic [4:0]                   packet_pixel_counter;
    logic                         audio_sample_valid;
    logic [2*AUDIO_BIT_WIDTH-1:0] audio_sample_word;
    logic                         acr_request;

    logic [7:0]                   packet_type;
    logic [4*2*24-1:0]            audio_sample_word_packet;
    logic [3:0]                   audio_sample_word_present;
    logic [7:0]                   frame_counter;
    logic [LEVEL_W-1:0]           fifo_level;
    logic                         fifo_overflow;

`ifdef PACKET_SCHEDULER_GCP_EN
    logic                         avmute;
    logic                         gcp_avmute;
`endif

    modport master (
`ifdef PACKET_SCHEDULER_GCP_EN
        output avmute,
        input  gcp_avmute,
`endif
        output video_field_end,
        output packet_enable,
        output packet_pixel_counter,
        output audio_sample_valid,
        output audio_sample_word,
        output acr_request,
        input  packet_type,
        input  audio_sample_word_packet,
        input  audio_sample_word_present,
        input  frame_counter,
        input  fifo_level,
        input  fifo_overflow
    );

    modport slave (
`ifdef PACKET_SCHEDULER_GCP_EN
        input  avmute,
        output gcp_avmute,
`endif
        input  video_field_end,
        input  packet_enable,
        input  packet_pixel_counter,
        input  audio_sample_valid,
        input  audio_sample_word,
        input  acr_request,
        output packet_type,
        output audio_sample_word_packet,
        output audio_sample_word_present,
        output frame_counter,
        output fifo_level,
        output fifo_overflow
    );
endinterface

// File: rtl/packet_scheduler.sv
// -----------------------------------------------------------------------------
// packet_scheduler
//
// Purpose: single-clock data-island packet choice. Buffers stereo audio sample
// pairs in a FIFO, packs up to MAX_SAMPLES_PER_PACKET of them per Audio Sample
// packet, and arbitrates audio > ACR > (GCP) > InfoFrames > null on every
// packet_enable pulse. The chosen packet_type and payload appear one clock
// after the pulse and hold until the next pulse.
//
// Ports:
//   clk_pixel  in   pixel clock, all logic
//   reset      in   synchronous, active-high
//   bus        packet_scheduler_if.slave (see interface header for members)
//
// Optional feature macro: PACKET_SCHEDULER_GCP_EN
//   Adds avmute / gcp_avmute and schedules a General Control packet (8'h03)
//   between ACR and InfoFrames. Without it, 8'h03 is never produced.
// -----------------------------------------------------------------------------
module packet_scheduler #(
    parameter int                          AUDIO_BIT_WIDTH        = 24,
    parameter int                          FIFO_DEPTH             = 8,
    parameter int                          MAX_SAMPLES_PER_PACKET = 4,
    parameter int                          NUM_INFOFRAMES         = 3,
    parameter logic [NUM_INFOFRAMES*8-1:0] INFOFRAME_TYPES        = {8'h83, 8'h82, 8'h84},
    parameter int                          INFOFRAME_PERIOD       = 2
) (
    input logic               clk_pixel,
    input logic               reset,
    packet_scheduler_if.slave bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int FIELD_W = (INFOFRAME_PERIOD > 1) ? $clog2(INFOFRAME_PERIOD) : 1;
    localparam int AW      = AUDIO_BIT_WIDTH;

    localparam logic [7:0] PKT_NULL  = 8'h00;
    localparam logic [7:0] PKT_ACR   = 8'h01;
    localparam logic [7:0] PKT_AUDIO = 8'h02;
`ifdef PACKET_SCHEDULER_GCP_EN
    localparam logic [7:0] PKT_GCP   = 8'h03;
`endif

    // Samples narrower than 24 bits are left-justified in their payload slot.
    function automatic logic [23:0] justify(input logic [AW-1:0] s);
        return 24'(s) << (24 - AW);
    endfunction

    // Sample storage; plain data path, no reset.
    logic [2*AW-1:0]          fifo_mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]          level_q, level_d;
    logic                      overflow_q, overflow_d;
    logic [7:0]                packet_type_q, packet_type_d;
    logic [4*2*24-1:0]         payload_q, payload_d;
    logic [3:0]                present_q, present_d;
    logic [7:0]                frame_cnt_q, frame_cnt_d;
    logic                      acr_pending_q, acr_pending_d;
    logic [NUM_INFOFRAMES-1:0] if_due_q, if_due_d;
    logic [FIELD_W-1:0]        field_cnt_q, field_cnt_d;

    logic                      full;
    logic                      push_en;
    logic [LVL_W-1:0]          pop_n;
    logic                      sel_acr;
    logic                      sel_if;
    logic                      if_hit;
    logic [7:0]                if_type;
    logic [NUM_INFOFRAMES-1:0] if_pick;
    logic [NUM_INFOFRAMES-1:0] if_clear;
    logic                      field_wrap;
    logic [2*AW-1:0]           pair;
    logic [2:0]                pop_sum;
    logic [8:0]                frame_sum;

`ifdef PACKET_SCHEDULER_GCP_EN
    logic gcp_due_q, gcp_due_d;
    logic gcp_avmute_q, gcp_avmute_d;
    logic avmute_prev_q;
    logic sel_gcp;
`endif

    always_comb begin
        // NOTE: every combinational output is given a default before any
        // branch, so no path leaves it unassigned and no latch is inferred.
        full          = (level_q == LVL_W'(FIFO_DEPTH));
        push_en       = bus.audio_sample_valid && !full;
        pop_n         = '0;
        sel_acr       = 1'b0;
        sel_if        = 1'b0;
        pair          = '0;
        packet_type_d = packet_type_q;
        payload_d     = payload_q;
        present_d     = present_q;
`ifdef PACKET_SCHEDULER_GCP_EN
        sel_gcp       = 1'b0;
        gcp_avmute_d  = gcp_avmute_q;
`endif

        // Lowest-index due InfoFrame: scan downwards so the last hit wins.
        if_hit  = 1'b0;
        if_type = PKT_NULL;
        if_pick = '0;
        for (int i = NUM_INFOFRAMES - 1; i >= 0; i--) begin
            if (if_due_q[i]) begin
                if_hit     = 1'b1;
                if_type    = INFOFRAME_TYPES[i*8 +: 8];
                if_pick    = '0;
                if_pick[i] = 1'b1;
            end
        end

        if (bus.packet_enable) begin
            payload_d = '0;
            present_d = '0;
            if (level_q != '0) begin
                pop_n = (level_q > LVL_W'(MAX_SAMPLES_PER_PACKET)) ?
                        LVL_W'(MAX_SAMPLES_PER_PACKET) : level_q;
                packet_type_d = PKT_AUDIO;
                for (int k = 0; k < 4; k++) begin
                    if (LVL_W'(k) < pop_n) begin
                        pair                     = fifo_mem_q[rd_ptr_q + PTR_W'(k)];
                        payload_d[k*48 +: 24]    = justify(pair[AW-1:0]);
                        payload_d[k*48+24 +: 24] = justify(pair[2*AW-1:AW]);
                        present_d[k]             = 1'b1;
                    end
                end
            end else if (acr_pending_q) begin
                sel_acr       = 1'b1;
                packet_type_d = PKT_ACR;
`ifdef PACKET_SCHEDULER_GCP_EN
            end else if (gcp_due_q) begin
                sel_gcp       = 1'b1;
                packet_type_d = PKT_GCP;
                gcp_avmute_d  = bus.avmute;
`endif
            end else if (if_hit) begin
                sel_if        = 1'b1;
                packet_type_d = if_type;
            end else begin
                packet_type_d = PKT_NULL;
            end
        end

        // Occupancy uses the pre-cycle full flag, so a same-cycle pop never
        // makes room for a push.
        level_d    = level_q + LVL_W'(push_en) - pop_n;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_en);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_n);
        overflow_d = overflow_q | (bus.audio_sample_valid & full);

        // A new request wins over a same-cycle ACR selection.
        acr_pending_d = bus.acr_request | (acr_pending_q & ~sel_acr);

        field_wrap  = bus.video_field_end &&
                      (field_cnt_q == FIELD_W'(INFOFRAME_PERIOD - 1));
        field_cnt_d = field_cnt_q;
        if (bus.video_field_end) begin
            field_cnt_d = field_wrap ? '0 : field_cnt_q + 1'b1;
        end
        if_clear = sel_if ? if_pick : '0;
        if_due_d = field_wrap ? '1 : (if_due_q & ~if_clear);

`ifdef PACKET_SCHEDULER_GCP_EN
        gcp_due_d = (gcp_due_q & ~sel_gcp) | bus.video_field_end |
                    (bus.avmute != avmute_prev_q);
`endif

        // Frame index advances by the number of samples in the packet being
        // sent, checked at its last pixel; wraps at 192 frames.
        pop_sum = '0;
        for (int k = 0; k < 4; k++) begin
            pop_sum = pop_sum + 3'(present_q[k]);
        end
        frame_sum   = {1'b0, frame_cnt_q} + 9'(pop_sum);
        frame_cnt_d = frame_cnt_q;
        if (bus.packet_pixel_counter == 5'd31 && packet_type_q == PKT_AUDIO) begin
            frame_cnt_d = (frame_sum >= 9'd192) ? 8'(frame_sum - 9'd192) : frame_sum[7:0];
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
            packet_type_q <= PKT_NULL;
            payload_q     <= '0;
            present_q     <= '0;
            frame_cnt_q   <= '0;
            acr_pending_q <= 1'b0;
            if_due_q      <= '1;
            field_cnt_q   <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            level_q       <= level_d;
            overflow_q    <= overflow_d;
            packet_type_q <= packet_type_d;
            payload_q     <= payload_d;
            present_q     <= present_d;
            frame_cnt_q   <= frame_cnt_d;
            acr_pending_q <= acr_pending_d;
            if_due_q      <= if_due_d;
            field_cnt_q   <= field_cnt_d;
        end
    end

    // NOTE: the sample array is deliberately not reset; emptiness is tracked
    // by the pointers and level, so stale contents are never read.
    always_ff @(posedge clk_pixel) begin
        if (push_en) begin
            fifo_mem_q[wr_ptr_q] <= bus.audio_sample_word;
        end
    end

`ifdef PACKET_SCHEDULER_GCP_EN
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            gcp_due_q     <= 1'b1;
            gcp_avmute_q  <= 1'b0;
            avmute_prev_q <= 1'b0;
        end else begin
            gcp_due_q     <= gcp_due_d;
            gcp_avmute_q  <= gcp_avmute_d;
            avmute_prev_q <= bus.avmute;
        end
    end
    assign bus.gcp_avmute = gcp_avmute_q;
`endif

    assign bus.packet_type               = packet_type_q;
    assign bus.audio_sample_word_packet  = payload_q;
    assign bus.audio_sample_word_present = present_q;
    assign bus.frame_counter             = frame_cnt_q;
    assign bus.fifo_level                = level_q;
    assign bus.fifo_overflow             = overflow_q;
endmodule
